// File: rtl/reg8file_reader_if.sv
// Output stream of the register-file reader: one byte plus its register index.
// A beat transfers on a rising edge where out_valid and out_ready are both high.
interface reg8file_reader_if #(
    parameter int DW = 8,
    parameter int IW = 3
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;

    modport master (output out_valid, output out_data, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_data, input out_idx, output out_ready);
endinterface

// File: rtl/reg8file_reader.sv
// Read-side sequencer for the 8x8 register file: walks a latched mask in ascending
// index order, streams each selected byte with its index and keeps a mod-256 checksum.
module reg8file_reader #(
    parameter int NREG = 8,
    parameter int DW   = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic [NREG-1:0]    mask,
    output logic [2:0]         rsel,
    input  logic [DW-1:0]      q,
    reg8file_reader_if.master  stream,
    output logic               busy,
    output logic               done,
    output logic [DW-1:0]      sum,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, SEND = 2'd2, FIN = 2'd3} state_t;

    state_t          state, state_nxt;
    logic [NREG-1:0] mask_r;
    logic [NREG-1:0] above;
    logic [DW-1:0]   acc;
    logic [3:0]      first_hit;
    logic [3:0]      next_hit;
    logic            hs;

    // Returns {found, index} of the lowest set bit.
    function automatic logic [3:0] lowest_set(input logic [NREG-1:0] m);
        lowest_set = 4'd0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = {1'b1, i[2:0]};
        end
    endfunction

    always_comb begin
        above     = mask_r & (8'hFE << rsel);
        first_hit = lowest_set(mask);
        next_hit  = lowest_set(above);
        hs        = stream.out_valid & stream.out_ready;
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (mask == '0) ? FIN : SCAN;
            SCAN: state_nxt = SEND;
            SEND: if (hs) state_nxt = next_hit[3] ? SCAN : FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state            <= IDLE;
            rsel             <= '0;
            mask_r           <= '0;
            acc              <= '0;
            sum              <= '0;
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            stream.out_idx   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_r <= mask;
                        acc    <= '0;
                        if (first_hit[3]) rsel <= first_hit[2:0];
                    end
                end
                // rsel has been stable a full cycle, so the file's q is settled here.
                SCAN: begin
                    stream.out_data  <= q;
                    stream.out_idx   <= rsel;
                    stream.out_valid <= 1'b1;
                    acc              <= acc + q;
                end
                SEND: begin
                    if (hs) begin
                        stream.out_valid <= 1'b0;
                        if (next_hit[3]) rsel <= next_hit[2:0];
                    end
                end
                FIN:     sum <= acc;
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign dbg_state = state;
endmodule

// File: tb/tb_reg8file_reader.sv
// Self-checking bench for reg8file_reader: table of scans plus hand-written
// back-pressure, reset-mid-scan and ignored-start sequences.
module tb_reg8file_reader;
  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [2:0] rsel;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic [1:0] dbg_state;
  logic [7:0] regs [8];

  reg8file_reader_if bus ();

  assign q = regs[rsel];

  reg8file_reader dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .mask      (mask),
    .rsel      (rsel),
    .q         (q),
    .stream    (bus.master),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [10:0] exp_q[$];
  int          rdy_mode = 0;
  int          beat_cnt = 0;
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic [2:0]  prev_idx = 3'd0;
  logic [7:0]  last_sum = 8'h00;

  typedef struct {
    logic [7:0] mask;
    int         preset;
    int         mode;
    int         beats;
    logic [7:0] sum;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_regs(input int preset);
    for (int i = 0; i < 8; i++) regs[i] = (preset == 0) ? 8'h10 + 8'(i) : 8'($urandom);
    if (preset == 1) begin
      regs[1] = 8'hFF;
      regs[7] = 8'h02;
    end
  endtask

  task automatic push_expected(input logic [7:0] m);
    for (int i = 0; i < 8; i++)
      if (m[i]) exp_q.push_back({3'(i), regs[i]});
  endtask

  // scoreboard / monitor: drives out_ready and pops on each handshake
  always @(negedge clk) begin
    logic [10:0] e;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
    if (!clr_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
        check("stall_idx", bus.out_idx, prev_idx);
      end
      if (bus.out_valid && bus.out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {bus.out_idx, bus.out_data}, 11'h7FF);
        end else begin
          e = exp_q.pop_front();
          check("beat", {bus.out_idx, bus.out_data}, e);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_idx   = bus.out_idx;
      if (done) done_cnt++;
    end
  end

  // driver: one accepted start, then wait (bounded) for done
  task automatic run_scan(input logic [7:0] m, input int exp_beats, input logic [7:0] exp_sum,
                          input int mode, input bit ign);
    int cycles;
    int d0;
    int b0;
    bit got;
    rdy_mode = mode;
    push_expected(m);
    d0 = done_cnt;
    b0 = beat_cnt;
    @(negedge clk);
    start = 1'b1;
    mask = m;
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (cycles == 1) begin
        start = 1'b0;
        mask = 8'($urandom);
        if (m != 8'h00) begin
          check("lat_busy", busy, 1);
          check("lat_valid_low", bus.out_valid, 0);
        end
      end
      if (cycles == 2 && m != 8'h00) begin
        check("lat_valid", bus.out_valid, 1);
        check("sum_hold", sum, last_sum);
      end
      if (ign && cycles == 3) begin
        start = 1'b1;
        mask = 8'h01;
      end
      if (ign && cycles == 4) start = 1'b0;
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1);
    if (mode == 0) check("done_cycle", cycles, 2 * exp_beats + 1);
    @(negedge clk);
    check("sum", sum, exp_sum);
    check("busy_after", busy, 0);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("beats", beat_cnt - b0, exp_beats);
    check("queue_empty", exp_q.size(), 0);
    check("sum_kept", sum, exp_sum);
    exp_q.delete();
    last_sum = exp_sum;
    rdy_mode = 0;
  endtask

  initial begin
    int b0;
    int d0;
    bit hit;

    vecs[0] = '{8'hFF, 0, 0, 8, 8'h9C};
    vecs[1] = '{8'h82, 1, 0, 2, 8'h01};
    vecs[2] = '{8'h00, 0, 0, 0, 8'h00};
    vecs[3] = '{8'h55, 0, 1, 4, 8'h4C};
    vecs[4] = '{8'hAA, 0, 1, 4, 8'h50};
    vecs[5] = '{8'h81, 0, 0, 2, 8'h27};
    vecs[6] = '{8'h80, 0, 1, 1, 8'h17};
    vecs[7] = '{8'h3C, 0, 0, 4, 8'h4E};
    vecs[8] = '{8'hFF, 0, 1, 8, 8'h9C};

    set_regs(0);
    repeat (2) @(negedge clk);
    check("rst_rsel", rsel, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_state", dbg_state, 0);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 9; v++) begin
      set_regs(vecs[v].preset);
      run_scan(vecs[v].mask, vecs[v].beats, vecs[v].sum, vecs[v].mode, 1'b0);
    end

    // back-pressure on a single beat
    set_regs(0);
    push_expected(8'h01);
    rdy_mode = 2;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    mask = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("bp_valid", bus.out_valid, 1);
    check("bp_data", bus.out_data, 8'h10);
    check("bp_idx", bus.out_idx, 0);
    check("bp_no_done", done_cnt - d0, 0);
    rdy_mode = 0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      if (done) hit = 1'b1;
    end
    check("bp_done", hit, 1);
    @(negedge clk);
    check("bp_sum", sum, 8'h10);
    check("bp_queue", exp_q.size(), 0);
    exp_q.delete();
    last_sum = 8'h10;

    // ignored start while busy
    set_regs(0);
    run_scan(8'hFF, 8, 8'h9C, 0, 1'b1);

    // asynchronous reset during the third SEND
    set_regs(0);
    push_expected(8'hFF);
    b0 = beat_cnt;
    @(negedge clk);
    start = 1'b1;
    mask = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(posedge clk);
      #2;
      if (bus.out_valid && (beat_cnt - b0) == 2) hit = 1'b1;
    end
    check("rst_mid_reached", hit, 1);
    clr_n = 1'b0;
    #1;
    check("mid_rsel", rsel, 0);
    check("mid_valid", bus.out_valid, 0);
    check("mid_data", bus.out_data, 0);
    check("mid_idx", bus.out_idx, 0);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_sum", sum, 0);
    check("mid_state", dbg_state, 0);
    exp_q.delete();
    @(negedge clk);
    clr_n = 1'b1;
    last_sum = 8'h00;
    run_scan(8'hFF, 8, 8'h9C, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
